// File: rtl/shreg_pkg.sv
// Shared constants for the universal shift register: operating modes and shift directions.
package shreg_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shreg_burst_ctrl.sv
// Burst sequencer: tracks the remaining step count, raises busy during a burst and
// pulses done for one cycle after the last step. Issues load/step strobes to the datapath.
module shreg_burst_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic start,
  output logic load,
  output logic step,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign step = enb & busy_q;
  assign load = enb & ~busy_q & start;
  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    // done is a pulse: it drops on the next edge even while enb is low
    done_d = 1'b0;
    if (step) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (load) begin
      cnt_d  = CNT_W'(WIDTH);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/shreg_univ.sv
// WIDTH-generic universal shift register with rotate and an autonomous burst serialiser.
// Optional feature macro: SHREG_ARITH_EN adds the arith port (sign-fill on right shifts).
module shreg_univ
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
`ifdef SHREG_ARITH_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  logic             load, step;
  logic             arith_sel;
  logic             shift_fill;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;

`ifdef SHREG_ARITH_EN
  assign arith_sel = arith;
`else
  assign arith_sel = 1'b0;
`endif

  shreg_burst_ctrl #(.WIDTH(WIDTH)) u_burst_ctrl (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .start (start),
    .load  (load),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  // Returns {outgoing bit, shifted word}.
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v,
                                            input logic right,
                                            input logic fill);
    if (right == DIR_LEFT) shift1 = {v[WIDTH-1], v[WIDTH-2:0], fill};
    else                   shift1 = {v[0], fill, v[WIDTH-1:1]};
  endfunction

  // Sign fill applies to right shifts only; rotates never use this fill.
  assign shift_fill = (dir == DIR_RIGHT && arith_sel) ? reg_q[WIDTH-1] : s_in;

  always_comb begin
    reg_d  = reg_q;
    sout_d = sout_q;
    if (step) begin
      {sout_d, reg_d} = shift1(reg_q, dir, shift_fill);
    end else if (load) begin
      reg_d = d;
    end else if (enb) begin
      case (mode)
        MODE_SHIFT:  {sout_d, reg_d} = shift1(reg_q, dir, shift_fill);
        MODE_LOAD:   reg_d = d;
        MODE_ROTATE: {sout_d, reg_d} = shift1(reg_q, dir,
                       (dir == DIR_RIGHT) ? reg_q[0] : reg_q[WIDTH-1]);
        MODE_HOLD:   ;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q  <= '0;
      sout_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      sout_q <= sout_d;
    end
  end

  assign q     = reg_q;
  assign s_out = sout_q;

endmodule
